// File: rtl/ps2_key_event_fifo_if.sv
// Key-event bus between the PS/2 key-event FIFO and its surroundings.
// The master side drives the decoder word and consumer controls; the slave
// side (the FIFO block) drives the event and status outputs.
interface ps2_key_event_fifo_if #(
  parameter int CW = 3
);
  logic [9:0]    key_code;
  logic          evt_ready;
  logic          ovf_clr;
  logic          evt_valid;
  logic [7:0]    evt_ascii;
  logic [CW-1:0] fifo_count;
  logic          shift_held;
  logic          caps_lock;
  logic          overflow;

  modport master (
    output key_code, evt_ready, ovf_clr,
    input  evt_valid, evt_ascii, fifo_count, shift_held, caps_lock, overflow
  );

  modport slave (
    input  key_code, evt_ready, ovf_clr,
    output evt_valid, evt_ascii, fifo_count, shift_held, caps_lock, overflow
  );
endinterface

// File: rtl/ps2_key_event_fifo.sv
// PS/2 key-event FIFO: turns new make codes from the keyboard decoder into
// ASCII events, tracks Shift / Caps Lock, and queues printable presses in a
// small FIFO with a valid/ready output handshake and a sticky overflow flag.
module ps2_key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  ps2_key_event_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [9:0]    r_key_prev;
  logic          r_shift_l;
  logic          r_shift_r;
  logic          r_caps;
  logic          r_ovf;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_last;
  logic [7:0]    r_mem [DEPTH];

  logic       w_new;
  logic       w_brk;
  logic       w_ext;
  logic [7:0] w_scan;
  logic       w_upper;
  logic [4:0] w_lidx;
  logic [3:0] w_didx;
  logic       w_mapped;
  logic [7:0] w_ascii;
  logic       w_print;
  logic       w_valid;
  logic       w_full;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;

  assign w_brk   = bus.key_code[9];
  assign w_ext   = bus.key_code[8];
  assign w_scan  = bus.key_code[7:0];
  assign w_new   = (bus.key_code != r_key_prev);
  // Shift/Caps used for a press are the registered values, i.e. the state before it.
  assign w_upper = (r_shift_l | r_shift_r) ^ r_caps;

  // Letter scancode -> alphabet index; 31 marks "not a letter".
  always_comb begin
    w_lidx = 5'd31;
    case (w_scan)
      8'h1C: w_lidx = 5'd0;   8'h32: w_lidx = 5'd1;   8'h21: w_lidx = 5'd2;
      8'h23: w_lidx = 5'd3;   8'h24: w_lidx = 5'd4;   8'h2B: w_lidx = 5'd5;
      8'h34: w_lidx = 5'd6;   8'h33: w_lidx = 5'd7;   8'h43: w_lidx = 5'd8;
      8'h3B: w_lidx = 5'd9;   8'h42: w_lidx = 5'd10;  8'h4B: w_lidx = 5'd11;
      8'h3A: w_lidx = 5'd12;  8'h31: w_lidx = 5'd13;  8'h44: w_lidx = 5'd14;
      8'h4D: w_lidx = 5'd15;  8'h15: w_lidx = 5'd16;  8'h2D: w_lidx = 5'd17;
      8'h1B: w_lidx = 5'd18;  8'h2C: w_lidx = 5'd19;  8'h3C: w_lidx = 5'd20;
      8'h2A: w_lidx = 5'd21;  8'h1D: w_lidx = 5'd22;  8'h22: w_lidx = 5'd23;
      8'h35: w_lidx = 5'd24;  8'h1A: w_lidx = 5'd25;
      default: w_lidx = 5'd31;
    endcase
  end

  // Digit scancode -> digit value; 15 marks "not a digit".
  always_comb begin
    w_didx = 4'd15;
    case (w_scan)
      8'h45: w_didx = 4'd0;  8'h16: w_didx = 4'd1;  8'h1E: w_didx = 4'd2;
      8'h26: w_didx = 4'd3;  8'h25: w_didx = 4'd4;  8'h2E: w_didx = 4'd5;
      8'h36: w_didx = 4'd6;  8'h3D: w_didx = 4'd7;  8'h3E: w_didx = 4'd8;
      8'h46: w_didx = 4'd9;
      default: w_didx = 4'd15;
    endcase
  end

  // Final ASCII value and whether the scancode is printable at all.
  always_comb begin
    w_ascii  = 8'h00;
    w_mapped = 1'b1;
    if (w_lidx != 5'd31) begin
      w_ascii = (w_upper ? 8'h41 : 8'h61) + {3'b000, w_lidx};
    end else if (w_didx != 4'd15) begin
      w_ascii = 8'h30 + {4'h0, w_didx};
    end else begin
      case (w_scan)
        8'h29:   w_ascii = 8'h20;
        8'h5A:   w_ascii = 8'h0D;
        8'h66:   w_ascii = 8'h08;
        default: w_mapped = 1'b0;
      endcase
    end
  end

  assign w_print = w_new & ~w_brk & ~w_ext & w_mapped;
  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = w_valid & bus.evt_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push  = w_print & (~w_full | w_pop);
  assign w_drop  = w_print & w_full & ~w_pop;

  // Change detector history and Shift / Caps Lock state tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_prev <= 10'd0;
      r_shift_l  <= 1'b0;
      r_shift_r  <= 1'b0;
      r_caps     <= 1'b0;
    end else begin
      r_key_prev <= bus.key_code;
      if (w_new && !w_ext) begin
        if (w_scan == 8'h12) r_shift_l <= ~w_brk;
        if (w_scan == 8'h59) r_shift_r <= ~w_brk;
        if (w_scan == 8'h58 && !w_brk) r_caps <= ~r_caps;
      end
    end
  end

  // FIFO storage; contents need no reset since only occupied slots are read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_ascii;
  end

  // Pointers, occupancy, last-popped value and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= 8'h00;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_last   <= r_mem[r_rd_ptr];
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_drop)           r_ovf <= 1'b1;
      else if (bus.ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign bus.evt_valid  = w_valid;
  // With the FIFO empty the most recently consumed event stays on the bus.
  assign bus.evt_ascii  = w_valid ? r_mem[r_rd_ptr] : r_last;
  assign bus.fifo_count = r_count;
  assign bus.shift_held = r_shift_l | r_shift_r;
  assign bus.caps_lock  = r_caps;
  assign bus.overflow   = r_ovf;
endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Testbench for ps2_key_event_fifo: directed scenarios followed by random
// key traffic, all checked against a queue-based reference model.
module tb_ps2_key_event_fifo;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  ps2_key_event_fifo_if #(.CW(CW)) bus ();

  ps2_key_event_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] q[$];
  bit         m_shl, m_shr, m_caps, m_ovf;
  logic [9:0] m_prev;
  logic [7:0] m_last;
  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] pool [16] = '{8'h1C, 8'h32, 8'h12, 8'h59, 8'h58, 8'h16, 8'h45, 8'h29,
                            8'h5A, 8'h66, 8'h1A, 8'h4D, 8'h3E, 8'h46, 8'h00, 8'h7F};

  function automatic void model_reset();
    q.delete();
    m_shl = 0; m_shr = 0; m_caps = 0; m_ovf = 0;
    m_prev = 10'd0; m_last = 8'h00;
  endfunction

  function automatic bit lookup(input logic [7:0] s, input bit up, output logic [7:0] a);
    a = 8'h00;
    for (int i = 0; i < 26; i++)
      if (letters[i] == s) begin a = (up ? 8'h41 : 8'h61) + 8'(i); return 1; end
    for (int i = 0; i < 10; i++)
      if (digits[i] == s) begin a = 8'h30 + 8'(i); return 1; end
    if (s == 8'h29) begin a = 8'h20; return 1; end
    if (s == 8'h5A) begin a = 8'h0D; return 1; end
    if (s == 8'h66) begin a = 8'h08; return 1; end
    return 0;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  function automatic void model_edge();
    logic [9:0] k;
    logic [7:0] a;
    bit pop, pr;
    k = bus.key_code;
    pr = 0;
    pop = (q.size() != 0) && bus.evt_ready;
    if (k != m_prev && !k[8]) begin
      if (k[7:0] == 8'h12) m_shl = !k[9];
      else if (k[7:0] == 8'h59) m_shr = !k[9];
      else if (k[7:0] == 8'h58) begin if (!k[9]) m_caps = !m_caps; end
      else if (!k[9]) pr = lookup(k[7:0], (m_shl | m_shr) ^ m_caps, a);
    end
    m_prev = k;
    if (pop) m_last = q.pop_front();
    if (pr && q.size() >= DEPTH) m_ovf = 1;
    else begin
      if (pr) q.push_back(a);
      if (bus.ovf_clr) m_ovf = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(bus.evt_valid), 32'(q.size() != 0));
    chk({tag, ".ascii"}, 32'(bus.evt_ascii), 32'((q.size() != 0) ? q[0] : m_last));
    chk({tag, ".count"}, 32'(bus.fifo_count), 32'(q.size()));
    chk({tag, ".shift"}, 32'(bus.shift_held), 32'(m_shl | m_shr));
    chk({tag, ".caps"}, 32'(bus.caps_lock), 32'(m_caps));
    chk({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
  endtask

  task automatic tick();
    if (!rst_n) model_reset();
    else model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [9:0] k, input string tag);
    bus.key_code = k;
    tick();
    check_all(tag);
  endtask

  initial begin
    logic [7:0] s;
    bus.key_code = 10'd0;
    bus.evt_ready = 1'b0;
    bus.ovf_clr = 1'b0;
    model_reset();
    #1;
    check_all("reset0");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check_all("post_reset");

    // 1: single 'a' then consume
    press(10'h01C, "t1_press");
    chk("t1_ascii_61", 32'(bus.evt_ascii), 32'h61);
    chk("t1_valid", 32'(bus.evt_valid), 32'd1);
    bus.evt_ready = 1'b1;
    tick();
    check_all("t1_pop");
    chk("t1_count0", 32'(bus.fifo_count), 32'd0);

    // 2: shifted 'A'
    press(10'h012, "t2_shdn");
    chk("t2_shift1", 32'(bus.shift_held), 32'd1);
    press(10'h01C, "t2_A");
    chk("t2_ascii_41", 32'(bus.evt_ascii), 32'h41);
    press(10'h21C, "t2_brk");
    press(10'h212, "t2_shup");
    chk("t2_shift0", 32'(bus.shift_held), 32'd0);

    // 3: Caps Lock, then Shift cancels Caps
    press(10'h058, "t3_caps");
    press(10'h258, "t3_capsbrk");
    chk("t3_caps1", 32'(bus.caps_lock), 32'd1);
    press(10'h032, "t3_B");
    chk("t3_ascii_42", 32'(bus.evt_ascii), 32'h42);
    press(10'h012, "t3_shdn");
    press(10'h032, "t3_b");
    chk("t3_ascii_62", 32'(bus.evt_ascii), 32'h62);
    press(10'h212, "t3_shup");
    press(10'h058, "t3_caps2");
    press(10'h258, "t3_capsbrk2");
    chk("t3_caps0", 32'(bus.caps_lock), 32'd0);
    tick(); check_all("t3_idle");

    // 4: overflow with a stalled consumer, then drain order
    bus.evt_ready = 1'b0;
    press(10'h016, "t4_p1"); press(10'h216, "t4_b1");
    press(10'h01E, "t4_p2"); press(10'h21E, "t4_b2");
    press(10'h026, "t4_p3"); press(10'h226, "t4_b3");
    press(10'h025, "t4_p4"); press(10'h225, "t4_b4");
    press(10'h02E, "t4_p5");
    chk("t4_count4", 32'(bus.fifo_count), 32'd4);
    chk("t4_ovf1", 32'(bus.overflow), 32'd1);
    press(10'h22E, "t4_b5");
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_head%0d", i), 32'(bus.evt_ascii), 32'h31 + 32'(i));
      tick();
      check_all("t4_drain");
    end

    // 5: push and pop together while full
    bus.evt_ready = 1'b0;
    bus.ovf_clr = 1'b1;
    tick(); check_all("t5_clr");
    bus.ovf_clr = 1'b0;
    chk("t5_ovf0", 32'(bus.overflow), 32'd0);
    press(10'h016, "t5_p1"); press(10'h216, "t5_b1");
    press(10'h01E, "t5_p2"); press(10'h21E, "t5_b2");
    press(10'h026, "t5_p3"); press(10'h226, "t5_b3");
    press(10'h025, "t5_p4"); press(10'h225, "t5_b4");
    bus.evt_ready = 1'b1;
    press(10'h02E, "t5_pushpop");
    chk("t5_count4", 32'(bus.fifo_count), 32'd4);
    chk("t5_ovf_stays0", 32'(bus.overflow), 32'd0);
    chk("t5_head32", 32'(bus.evt_ascii), 32'h32);
    press(10'h22E, "t5_d1");
    tick(); check_all("t5_d2");
    tick(); check_all("t5_d3");
    chk("t5_tail35", 32'(bus.evt_ascii), 32'h35);
    tick(); check_all("t5_d4");
    chk("t5_empty", 32'(bus.evt_valid), 32'd0);
    chk("t5_hold35", 32'(bus.evt_ascii), 32'h35);

    // 6: extended ignored, held code gives one event, async reset clears all
    bus.evt_ready = 1'b0;
    press(10'h11C, "t6_ext");
    chk("t6_ext_none", 32'(bus.fifo_count), 32'd0);
    press(10'h01C, "t6_hold1");
    tick(); check_all("t6_hold2");
    tick(); check_all("t6_hold3");
    chk("t6_one_evt", 32'(bus.fifo_count), 32'd1);
    press(10'h012, "t6_sh");
    press(10'h058, "t6_caps");
    press(10'h032, "t6_B");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_async_rst");
    chk("t6_rst_count", 32'(bus.fifo_count), 32'd0);
    chk("t6_rst_ascii", 32'(bus.evt_ascii), 32'd0);
    tick(); check_all("t6_in_rst");
    rst_n = 1'b1;
    tick(); check_all("t6_release");

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) != 0) begin
        s = ($urandom_range(0, 5) == 0) ? 8'($urandom) : pool[$urandom_range(0, 15)];
        bus.key_code = {1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0), s};
      end
      if (c < 700) bus.evt_ready = ($urandom_range(0, 3) == 0);
      else         bus.evt_ready = ($urandom_range(0, 3) != 0);
      bus.ovf_clr = ($urandom_range(0, 15) == 0);
      tick();
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
